// File: rtl/adder_byte_sequencer_if.sv
// Byte-stream and adder-operand bundle between the sequencer and its surroundings.
// Latency: none, wires only.
// Backpressure: in_valid/in_ready on the input stream, out_valid/out_ready on the result stream.
interface adder_byte_sequencer_if #(
    parameter int WIDTH = 16
);
    logic [7:0]       in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             cin;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
    logic [7:0]       out_data;
    logic             out_valid;
    logic             out_ready;
    logic             busy;

    // Environment side: byte source, adder core and result sink.
    modport master (
        output in_data, in_valid, add_sum, add_cout, out_ready,
        input  in_ready, op_a, op_b, cin, out_data, out_valid, busy
    );

    // Sequencer side.
    modport slave (
        input  in_data, in_valid, add_sum, add_cout, out_ready,
        output in_ready, op_a, op_b, cin, out_data, out_valid, busy
    );
endinterface

// File: rtl/adder_byte_sequencer.sv
// Byte-serial front/back end for the adder: command + A + B bytes in, sum bytes + flag byte out.
// Latency: EXEC is the single cycle after the last B byte; the first result byte is offered the cycle after.
// Backpressure: in_ready low outside CMD/LOAD states; SEND holds out_data/out_valid while out_ready=0.
// Optional feature: define ADDER_ACCUM_EN so a command with bit2 set reuses the previous result as A.
module adder_byte_sequencer #(
    parameter int WIDTH = 16
) (
    input logic               clk,
    input logic               rst,
    adder_byte_sequencer_if.slave bus
);
    localparam int NB = WIDTH / 8;
    localparam int CW = $clog2(NB + 1);

    typedef enum logic [2:0] {
        S_CMD    = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_B = 3'd2,
        S_EXEC   = 3'd3,
        S_SEND   = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_sub;
    logic             r_cin_req;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic             r_cin;
    logic [WIDTH-1:0] r_r;
    logic             r_c;

    logic             w_in_ready;
    logic             w_out_valid;
    logic [7:0]       w_out_data;
    logic             w_busy;
    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_last_ld;
    logic             w_v;
    logic [WIDTH-1:0] w_b_full;

    assign w_last_ld = (r_cnt == CW'(NB - 1));

    // Signed overflow of the sum actually presented to the adder.
    assign w_v = (r_op_a[WIDTH-1] == r_op_b[WIDTH-1]) && (r_r[WIDTH-1] != r_op_a[WIDTH-1]);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_CMD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake/output decode.
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_out_data  = 8'h00;
        w_busy      = 1'b1;
        case (r_state)
            S_CMD: begin
                w_in_ready = 1'b1;
                w_busy     = 1'b0;
                if (bus.in_valid) begin
`ifdef ADDER_ACCUM_EN
                    w_state_nxt = bus.in_data[2] ? S_LOAD_B : S_LOAD_A;
`else
                    w_state_nxt = S_LOAD_A;
`endif
                end
            end
            S_LOAD_A: begin
                w_in_ready = 1'b1;
                if (bus.in_valid && w_last_ld) w_state_nxt = S_LOAD_B;
            end
            S_LOAD_B: begin
                w_in_ready = 1'b1;
                if (bus.in_valid && w_last_ld) w_state_nxt = S_EXEC;
            end
            S_EXEC: begin
                w_state_nxt = S_SEND;
            end
            S_SEND: begin
                w_out_valid = 1'b1;
                for (int k = 0; k < NB; k++) begin
                    if (r_cnt == CW'(k)) w_out_data = r_r[k*8 +: 8];
                end
                if (r_cnt == CW'(NB)) w_out_data = {6'b0, w_v, r_c};
                if (bus.out_ready && (r_cnt == CW'(NB))) w_state_nxt = S_CMD;
            end
            default: begin
                w_state_nxt = S_CMD;
            end
        endcase
        w_in_fire  = w_in_ready && bus.in_valid;
        w_out_fire = w_out_valid && bus.out_ready;
    end

    // B with the byte currently on in_data merged in, so the operand register can load on the last byte.
    always_comb begin
        w_b_full = r_b;
        for (int k = 0; k < NB; k++) begin
            if (r_cnt == CW'(k)) w_b_full[k*8 +: 8] = bus.in_data;
        end
    end

    // Byte counter, operand assembly, adder drive registers and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_sub     <= 1'b0;
            r_cin_req <= 1'b0;
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_cin     <= 1'b0;
            r_r       <= '0;
            r_c       <= 1'b0;
        end else begin
            if (w_state_nxt != r_state) begin
                r_cnt <= '0;
            end else if (w_in_fire || w_out_fire) begin
                r_cnt <= r_cnt + CW'(1);
            end
            case (r_state)
                S_CMD: begin
                    if (w_in_fire) begin
                        r_cin_req <= bus.in_data[0];
                        r_sub     <= bus.in_data[1];
`ifdef ADDER_ACCUM_EN
                        r_a       <= r_r;
`endif
                    end
                end
                S_LOAD_A: begin
                    if (w_in_fire) begin
                        for (int k = 0; k < NB; k++) begin
                            if (r_cnt == CW'(k)) r_a[k*8 +: 8] <= bus.in_data;
                        end
                    end
                end
                S_LOAD_B: begin
                    if (w_in_fire) begin
                        r_b <= w_b_full;
                        if (w_last_ld) begin
                            r_op_a <= r_a;
                            r_op_b <= r_sub ? ~w_b_full : w_b_full;
                            r_cin  <= r_sub | r_cin_req;
                        end
                    end
                end
                S_EXEC: begin
                    r_r <= bus.add_sum;
                    r_c <= bus.add_cout;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = w_out_data;
    assign bus.busy      = w_busy;
    assign bus.op_a      = r_op_a;
    assign bus.op_b      = r_op_b;
    assign bus.cin       = r_cin;
endmodule

// File: tb/tb_adder_byte_sequencer.sv
// Bench for adder_byte_sequencer with WIDTH=16 and a behavioural adder on the operand lines.
// Expected result bytes are queued when a transaction is driven and popped as bytes come out.
// Covers reset, add/carry/subtract, overflow with backpressure, mid-op reset, accumulate, throughput.
module tb_adder_byte_sequencer;
    localparam int WIDTH = 16;
    localparam int NB    = WIDTH / 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    adder_byte_sequencer_if #(.WIDTH(WIDTH)) bus_if ();

    logic [WIDTH:0] add_full;
    assign add_full        = {1'b0, bus_if.op_a} + {1'b0, bus_if.op_b} + {{WIDTH{1'b0}}, bus_if.cin};
    assign bus_if.add_sum  = add_full[WIDTH-1:0];
    assign bus_if.add_cout = add_full[WIDTH];

    adder_byte_sequencer #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int               n_cmp = 0;
    int               n_err = 0;
    logic [7:0]       exp_q[$];
    logic [WIDTH-1:0] model_r;

    function automatic void push_exp(input logic [7:0] cmd, input logic [WIDTH-1:0] a,
                                     input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] ob;
        logic             ci;
        logic [WIDTH:0]   s;
        logic             v;
        ob = cmd[1] ? ~b : b;
        ci = cmd[1] | cmd[0];
        s  = {1'b0, a} + {1'b0, ob} + {{WIDTH{1'b0}}, ci};
        v  = (a[WIDTH-1] == ob[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
        for (int k = 0; k < NB; k++) exp_q.push_back(s[k*8 +: 8]);
        exp_q.push_back({6'b0, v, s[WIDTH]});
        model_r = s[WIDTH-1:0];
    endfunction

    task automatic send_byte(input logic [7:0] b);
        bus_if.in_data  = b;
        bus_if.in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus_if.in_ready) begin
                @(posedge clk);
                #1;
                bus_if.in_valid = 1'b0;
                return;
            end
        end
        n_cmp++;
        n_err++;
        $display("FAIL send_timeout: in_ready stayed 0 for 20 cycles, required 1");
        bus_if.in_valid = 1'b0;
    endtask

    task automatic recv_byte(output logic [7:0] d, output bit ok);
        ok = 1'b0;
        d  = 8'h00;
        bus_if.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus_if.out_valid) begin
                d = bus_if.out_data;
                @(posedge clk);
                #1;
                ok = 1'b1;
                bus_if.out_ready = 1'b0;
                return;
            end
        end
        bus_if.out_ready = 1'b0;
    endtask

    task automatic drive_txn(input logic [7:0] cmd, input logic [WIDTH-1:0] a,
                             input logic [WIDTH-1:0] b, input bit send_a);
        push_exp(cmd, a, b);
        send_byte(cmd);
        if (send_a) for (int k = 0; k < NB; k++) send_byte(a[k*8 +: 8]);
        for (int k = 0; k < NB; k++) send_byte(b[k*8 +: 8]);
    endtask

    task automatic test_reset();
        rst              = 1'b1;
        bus_if.in_valid  = 1'b0;
        bus_if.in_data   = 8'h00;
        bus_if.out_ready = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        n_cmp++;
        if ({bus_if.in_ready, bus_if.busy} !== 2'b10) begin
            n_err++;
            $display("FAIL reset_ready_busy: got %b, required 10", {bus_if.in_ready, bus_if.busy});
        end
        n_cmp++;
        if ({bus_if.out_valid, bus_if.out_data} !== 9'h000) begin
            n_err++;
            $display("FAIL reset_out: got %h, required 000", {bus_if.out_valid, bus_if.out_data});
        end
        n_cmp++;
        if ({bus_if.op_a, bus_if.op_b, bus_if.cin} !== {(2*WIDTH+1){1'b0}}) begin
            n_err++;
            $display("FAIL reset_ops: got a=%h b=%h cin=%b, required 0", bus_if.op_a, bus_if.op_b, bus_if.cin);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_r = '0;
    endtask

    task automatic test_add();
        logic [7:0] got, exp;
        bit         ok;
        drive_txn(8'h00, 16'h1234, 16'h0001, 1'b1);
        @(negedge clk);
        n_cmp++;
        if ({bus_if.in_ready, bus_if.busy, bus_if.out_valid, bus_if.out_data} !== 11'b010_0000_0000) begin
            n_err++;
            $display("FAIL add_exec_cycle: got rdy=%b busy=%b vld=%b dat=%h, required 0 1 0 00",
                     bus_if.in_ready, bus_if.busy, bus_if.out_valid, bus_if.out_data);
        end
        n_cmp++;
        if ({bus_if.op_a, bus_if.op_b, bus_if.cin} !== {16'h1234, 16'h0001, 1'b0}) begin
            n_err++;
            $display("FAIL add_ops: got a=%h b=%h cin=%b, required 1234 0001 0", bus_if.op_a, bus_if.op_b, bus_if.cin);
        end
        @(negedge clk);
        n_cmp++;
        if (bus_if.out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL add_latency: out_valid got %b, required 1", bus_if.out_valid);
        end
        @(posedge clk);
        #1;
        for (int k = 0; k <= NB; k++) begin
            recv_byte(got, ok);
            exp = exp_q.pop_front();
            n_cmp++;
            if (!ok || got !== exp) begin
                n_err++;
                $display("FAIL add_byte%0d: got %h (ok=%0d), required %h", k, got, ok, exp);
            end
        end
    endtask

    task automatic test_carry();
        logic [7:0] got, exp;
        bit         ok;
        drive_txn(8'h01, 16'hFFFF, 16'h0000, 1'b1);
        for (int k = 0; k <= NB; k++) begin
            recv_byte(got, ok);
            exp = exp_q.pop_front();
            n_cmp++;
            if (!ok || got !== exp) begin
                n_err++;
                $display("FAIL carry_byte%0d: got %h (ok=%0d), required %h", k, got, ok, exp);
            end
        end
    endtask

    task automatic test_sub();
        logic [7:0] got, exp;
        bit         ok;
        drive_txn(8'h02, 16'h0005, 16'h0007, 1'b1);
        @(negedge clk);
        n_cmp++;
        if ({bus_if.op_a, bus_if.op_b, bus_if.cin} !== {16'h0005, 16'hFFF8, 1'b1}) begin
            n_err++;
            $display("FAIL sub_ops: got a=%h b=%h cin=%b, required 0005 fff8 1", bus_if.op_a, bus_if.op_b, bus_if.cin);
        end
        @(posedge clk);
        #1;
        for (int k = 0; k <= NB; k++) begin
            recv_byte(got, ok);
            exp = exp_q.pop_front();
            n_cmp++;
            if (!ok || got !== exp) begin
                n_err++;
                $display("FAIL sub_byte%0d: got %h (ok=%0d), required %h", k, got, ok, exp);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] got, exp;
        bit         ok;
        drive_txn(8'h00, 16'h7FFF, 16'h0001, 1'b1);
        recv_byte(got, ok);
        exp = exp_q.pop_front();
        n_cmp++;
        if (!ok || got !== exp) begin
            n_err++;
            $display("FAIL bp_byte0: got %h (ok=%0d), required %h", got, ok, exp);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({bus_if.out_valid, bus_if.out_data, bus_if.in_ready} !== {1'b1, exp_q[0], 1'b0}) begin
                n_err++;
                $display("FAIL bp_stall%0d: got vld=%b dat=%h rdy=%b, required 1 %h 0",
                         i, bus_if.out_valid, bus_if.out_data, bus_if.in_ready, exp_q[0]);
            end
        end
        @(posedge clk);
        #1;
        for (int k = 1; k <= NB; k++) begin
            recv_byte(got, ok);
            exp = exp_q.pop_front();
            n_cmp++;
            if (!ok || got !== exp) begin
                n_err++;
                $display("FAIL bp_byte%0d: got %h (ok=%0d), required %h", k, got, ok, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] got, exp;
        bit         ok;
        bit         seen;
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if ({bus_if.in_ready, bus_if.busy, bus_if.out_valid} !== 3'b100) begin
            n_err++;
            $display("FAIL mid_reset_state: got rdy=%b busy=%b vld=%b, required 1 0 0",
                     bus_if.in_ready, bus_if.busy, bus_if.out_valid);
        end
        n_cmp++;
        if ({bus_if.op_a, bus_if.op_b, bus_if.cin} !== {(2*WIDTH+1){1'b0}}) begin
            n_err++;
            $display("FAIL mid_reset_ops: got a=%h b=%h cin=%b, required 0", bus_if.op_a, bus_if.op_b, bus_if.cin);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_r = '0;
        seen = 1'b0;
        bus_if.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus_if.out_valid) seen = 1'b1;
        end
        @(posedge clk);
        #1;
        bus_if.out_ready = 1'b0;
        n_cmp++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset_no_output: out_valid seen=%b, required 0", seen);
        end
        drive_txn(8'h01, 16'h00FF, 16'h0F00, 1'b1);
        for (int k = 0; k <= NB; k++) begin
            recv_byte(got, ok);
            exp = exp_q.pop_front();
            n_cmp++;
            if (!ok || got !== exp) begin
                n_err++;
                $display("FAIL mid_after_byte%0d: got %h (ok=%0d), required %h", k, got, ok, exp);
            end
        end
    endtask

    task automatic test_accum();
        logic [7:0] got, exp;
        bit         ok;
`ifdef ADDER_ACCUM_EN
        drive_txn(8'h00, 16'h1234, 16'h0001, 1'b1);
        for (int k = 0; k <= NB; k++) begin
            recv_byte(got, ok);
            exp = exp_q.pop_front();
            n_cmp++;
            if (!ok || got !== exp) begin
                n_err++;
                $display("FAIL acc_first_byte%0d: got %h (ok=%0d), required %h", k, got, ok, exp);
            end
        end
        drive_txn(8'h04, model_r, 16'h0001, 1'b0);
`else
        send_byte(8'h04);
        send_byte(8'h01);
        send_byte(8'h00);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({bus_if.in_ready, bus_if.busy, bus_if.out_valid} !== 3'b110) begin
                n_err++;
                $display("FAIL noacc_wait%0d: got rdy=%b busy=%b vld=%b, required 1 1 0",
                         i, bus_if.in_ready, bus_if.busy, bus_if.out_valid);
            end
        end
        @(posedge clk);
        #1;
        push_exp(8'h04, 16'h0001, 16'h0002);
        send_byte(8'h02);
        send_byte(8'h00);
`endif
        for (int k = 0; k <= NB; k++) begin
            recv_byte(got, ok);
            exp = exp_q.pop_front();
            n_cmp++;
            if (!ok || got !== exp) begin
                n_err++;
                $display("FAIL acc_byte%0d: got %h (ok=%0d), required %h", k, got, ok, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] got, exp;
        bit         ok;
        time        t0;
        t0 = $time;
        drive_txn(8'h01, 16'h8000, 16'h8000, 1'b1);
        n_cmp++;
        if ($time - t0 !== 50) begin
            n_err++;
            $display("FAIL b2b_input_rate1: got %0t for 5 bytes, required 50", $time - t0);
        end
        for (int k = 0; k <= NB; k++) begin
            recv_byte(got, ok);
            exp = exp_q.pop_front();
            n_cmp++;
            if (!ok || got !== exp) begin
                n_err++;
                $display("FAIL b2b_first_byte%0d: got %h (ok=%0d), required %h", k, got, ok, exp);
            end
        end
        t0 = $time;
        drive_txn(8'h02, 16'h8000, 16'h0001, 1'b1);
        n_cmp++;
        if ($time - t0 !== 50) begin
            n_err++;
            $display("FAIL b2b_input_rate2: got %0t for 5 bytes, required 50", $time - t0);
        end
        for (int k = 0; k <= NB; k++) begin
            recv_byte(got, ok);
            exp = exp_q.pop_front();
            n_cmp++;
            if (!ok || got !== exp) begin
                n_err++;
                $display("FAIL b2b_second_byte%0d: got %h (ok=%0d), required %h", k, got, ok, exp);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_carry();
        test_sub();
        test_backpressure();
        test_reset_mid();
        test_accum();
        test_back_to_back();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d bytes left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
